// File: rtl/unidade_acesso_memoria_pkg.sv
// unidade_acesso_memoria_pkg: size codes, FSM states and the alignment rule shared by the load/store unit
package unidade_acesso_memoria_pkg;
    localparam logic [1:0] TAM_BYTE      = 2'b00;
    localparam logic [1:0] TAM_MEIA      = 2'b01;
    localparam logic [1:0] TAM_PALAVRA   = 2'b10;
    localparam logic [1:0] TAM_RESERVADO = 2'b11;
    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        ACESSO = 2'b01,
        MESCLA = 2'b10,
        FIM    = 2'b11
    } estado_t;
    // The reserved size code is reported as a misalignment so it takes the same error path
    function automatic logic desalinhado(input logic [1:0] tam, input logic [1:0] a);
        return (tam == TAM_MEIA && a[0]) || (tam == TAM_PALAVRA && a != 2'b00) || tam == TAM_RESERVADO;
    endfunction
endpackage

// File: rtl/unidade_acesso_memoria_alinhador.sv
// unidade_acesso_memoria_alinhador: little-endian lane extraction with sign/zero extension and sub-word store merge
module unidade_acesso_memoria_alinhador
    import unidade_acesso_memoria_pkg::*;
#(
    parameter int LARG_DADO = 32
) (
    input  logic [LARG_DADO-1:0] palavra,
    input  logic [LARG_DADO-1:0] dado,
    input  logic [1:0]           endBaixo,
    input  logic [1:0]           tamanho,
    input  logic                 sinal,
    output logic [LARG_DADO-1:0] dadoCarregado,
    output logic [LARG_DADO-1:0] palavraMesclada
);
    logic [4:0]           deslocByte;
    logic [4:0]           deslocMeia;
    logic [7:0]           byteSel;
    logic [15:0]          meiaSel;
    logic [LARG_DADO-1:0] mascara;
    logic [LARG_DADO-1:0] inserido;
    always_comb begin
        deslocByte = {endBaixo, 3'b000};
        deslocMeia = {endBaixo[1], 4'b0000};
        byteSel = palavra[deslocByte +: 8];
        meiaSel = palavra[deslocMeia +: 16];
        dadoCarregado = tamanho == TAM_BYTE ? {{(LARG_DADO-8){sinal & byteSel[7]}}, byteSel}
                      : tamanho == TAM_MEIA ? {{(LARG_DADO-16){sinal & meiaSel[15]}}, meiaSel}
                      : palavra;
        // Only the addressed lanes are replaced; the rest of the word comes back from memory unchanged
        mascara = tamanho == TAM_BYTE ? LARG_DADO'(8'hFF) << deslocByte
                : tamanho == TAM_MEIA ? LARG_DADO'(16'hFFFF) << deslocMeia
                : '1;
        inserido = tamanho == TAM_BYTE ? LARG_DADO'(dado[7:0]) << deslocByte
                 : tamanho == TAM_MEIA ? LARG_DADO'(dado[15:0]) << deslocMeia
                 : dado;
        palavraMesclada = (palavra & ~mascara) | (inserido & mascara);
    end
endmodule

// File: rtl/unidade_acesso_memoria.sv
// unidade_acesso_memoria: load/store unit turning byte-addressed requests into whole-word memory accesses
module unidade_acesso_memoria
    import unidade_acesso_memoria_pkg::*;
#(
    parameter int LARG_DADO = 32,
    parameter int LARG_END  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ReqValido,
    input  logic                 ReqEscrita,
    input  logic [1:0]           ReqTamanho,
    input  logic                 ReqSinal,
    input  logic [31:0]          EndByte,
    input  logic [LARG_DADO-1:0] DadoEscrita,
    output logic                 Pronto,
    output logic                 Concluido,
    output logic                 Erro,
    output logic [LARG_DADO-1:0] DadoLido,
    output logic [LARG_END-1:0]  EndLeitura,
    output logic [LARG_END-1:0]  EndEscrita,
    output logic [LARG_DADO-1:0] DadoMemEscrita,
    output logic                 CTRLEscritaMem,
    input  logic [LARG_DADO-1:0] DadoMemoria
);
    estado_t              estado;
    estado_t              proxEstado;
    logic                 escritaReg;
    logic                 sinalReg;
    logic                 erroReg;
    logic [1:0]           tamReg;
    logic [LARG_END+1:0]  endReg;
    logic [LARG_DADO-1:0] dadoReg;
    logic [LARG_DADO-1:0] lidoReg;
    logic [LARG_DADO-1:0] mescladoReg;
    logic [LARG_DADO-1:0] carregado;
    logic [LARG_DADO-1:0] mesclado;
    logic                 aceite;
    logic                 erroNovo;
    logic                 unusedEnd;

    // Address bits above the memory range are dropped so accesses wrap around
    assign unusedEnd = ^EndByte[31:LARG_END+2];
    assign aceite    = estado == OCIOSO && ReqValido;
    assign erroNovo  = desalinhado(ReqTamanho, EndByte[1:0]);

    unidade_acesso_memoria_alinhador #(.LARG_DADO(LARG_DADO)) alinhador_bytes (
        .palavra        (DadoMemoria),
        .dado           (dadoReg),
        .endBaixo       (endReg[1:0]),
        .tamanho        (tamReg),
        .sinal          (sinalReg),
        .dadoCarregado  (carregado),
        .palavraMesclada(mesclado)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            estado <= OCIOSO;
        else
            estado <= proxEstado;
    end

    always_comb begin
        proxEstado = estado;
        case (estado)
            OCIOSO:  proxEstado = !aceite ? OCIOSO : erroNovo ? FIM : ACESSO;
            ACESSO:  proxEstado = (escritaReg && tamReg != TAM_PALAVRA) ? MESCLA : FIM;
            MESCLA:  proxEstado = FIM;
            default: proxEstado = OCIOSO;
        endcase
    end

    // Write enable depends on state and latched request only, so reset removes it immediately
    always_comb begin
        Pronto         = estado == OCIOSO;
        Concluido      = estado == FIM;
        Erro           = estado == FIM && erroReg;
        DadoLido       = lidoReg;
        EndLeitura     = endReg[LARG_END+1:2];
        EndEscrita     = endReg[LARG_END+1:2];
        CTRLEscritaMem = (estado == ACESSO && escritaReg && tamReg == TAM_PALAVRA) || estado == MESCLA;
        DadoMemEscrita = estado == MESCLA ? mescladoReg : dadoReg;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            escritaReg  <= 1'b0;
            sinalReg    <= 1'b0;
            erroReg     <= 1'b0;
            tamReg      <= TAM_BYTE;
            endReg      <= '0;
            dadoReg     <= '0;
            lidoReg     <= '0;
            mescladoReg <= '0;
        end else if (aceite) begin
            escritaReg <= ReqEscrita;
            sinalReg   <= ReqSinal;
            erroReg    <= erroNovo;
            tamReg     <= ReqTamanho;
            endReg     <= EndByte[LARG_END+1:0];
            dadoReg    <= DadoEscrita;
            if (erroNovo && !ReqEscrita)
                lidoReg <= '0;
        end else if (estado == ACESSO) begin
            if (!escritaReg)
                lidoReg <= carregado;
            mescladoReg <= mesclado;
        end
    end
endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// tb_unidade_acesso_memoria: randomized requests against a word-array reference model, checked by a scoreboard monitor
module tb_unidade_acesso_memoria;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ReqValido = 1'b0;
    logic        ReqEscrita = 1'b0;
    logic [1:0]  ReqTamanho = 2'b00;
    logic        ReqSinal = 1'b0;
    logic [31:0] EndByte = 32'h0;
    logic [31:0] DadoEscrita = 32'h0;
    logic        Pronto, Concluido, Erro, CTRLEscritaMem;
    logic [31:0] DadoLido, DadoMemEscrita, DadoMemoria;
    logic [7:0]  EndLeitura, EndEscrita;

    logic [31:0] mem    [256];
    logic [31:0] refMem [256];
    logic [31:0] refLido = 32'h0;
    logic        preloadEn = 1'b1;

    typedef struct {
        logic        erro;
        logic [31:0] lido;
        int          latencia;
        int          escritas;
        int          aceite;
    } esperado_t;
    esperado_t fila[$];

    int total = 0;
    int bad = 0;
    int ciclo = 0;
    int escritasVistas = 0;

    unidade_acesso_memoria dut (
        .CLK(CLK), .RST(RST), .ReqValido(ReqValido), .ReqEscrita(ReqEscrita),
        .ReqTamanho(ReqTamanho), .ReqSinal(ReqSinal), .EndByte(EndByte),
        .DadoEscrita(DadoEscrita), .Pronto(Pronto), .Concluido(Concluido), .Erro(Erro),
        .DadoLido(DadoLido), .EndLeitura(EndLeitura), .EndEscrita(EndEscrita),
        .DadoMemEscrita(DadoMemEscrita), .CTRLEscritaMem(CTRLEscritaMem),
        .DadoMemoria(DadoMemoria)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) ciclo++;

    // Main memory: combinational read, write on the clock edge
    assign DadoMemoria = mem[EndLeitura];
    always @(posedge CLK) begin
        if (preloadEn)
            for (int i = 0; i < 256; i++) mem[i] <= refMem[i];
        else if (CTRLEscritaMem)
            mem[EndEscrita] <= DadoMemEscrita;
    end

    function automatic void verifica(string nome, logic [31:0] obtido, logic [31:0] exigido);
        total++;
        if (obtido !== exigido) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nome, obtido, exigido);
        end
    endfunction

    always @(negedge CLK) begin
        if (RST)
            escritasVistas = 0;
        else begin
            if (CTRLEscritaMem) escritasVistas++;
            if (Concluido) begin
                if (fila.size() == 0)
                    verifica("concluido_inesperado", 32'd1, 32'd0);
                else begin
                    esperado_t e;
                    e = fila.pop_front();
                    verifica("erro", Erro, e.erro);
                    verifica("dado_lido", DadoLido, e.lido);
                    verifica("latencia", ciclo - e.aceite, e.latencia);
                    verifica("escritas", escritasVistas, e.escritas);
                    verifica("pronto_ocupado", Pronto, 0);
                end
                escritasVistas = 0;
            end
        end
    end

    task automatic aguardaPronto();
        int n = 0;
        @(negedge CLK);
        while (!Pronto && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!Pronto) verifica("timeout_pronto", Pronto, 1);
    endtask

    task automatic drena();
        int n = 0;
        while ((fila.size() != 0 || !Pronto) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (fila.size() != 0) verifica("timeout_fila", fila.size(), 0);
    endtask

    // Reference: word-array memory, byte lanes by address modulo 4, extension by arithmetic
    task automatic requisita(input logic esc, input logic [1:0] tam, input logic sin,
                             input logic [31:0] a, input logic [31:0] d);
        esperado_t e;
        int idx;
        int lane;
        logic [31:0] w;
        aguardaPronto();
        idx = int'((a / 4) % 256);
        lane = int'(a % 4);
        w = refMem[idx];
        e.erro = (tam == 2'd3) || (tam == 2'd1 && a % 2 != 0) || (tam == 2'd2 && lane != 0);
        e.escritas = (esc && !e.erro) ? 1 : 0;
        e.latencia = e.erro ? 1 : (esc && tam != 2'd2) ? 3 : 2;
        if (e.erro) begin
            if (!esc) refLido = 32'h0;
        end else if (esc) begin
            if (tam == 2'd2) refMem[idx] = d;
            else if (tam == 2'd1) refMem[idx] = (w & ~(32'hFFFF << (8 * lane))) | ((d % 65536) << (8 * lane));
            else refMem[idx] = (w & ~(32'hFF << (8 * lane))) | ((d % 256) << (8 * lane));
        end else if (tam == 2'd2)
            refLido = w;
        else begin
            int bits;
            longint v;
            bits = (tam == 2'd1) ? 16 : 8;
            v = longint'((w >> (8 * lane)) % (32'd1 << bits));
            if (sin && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
            refLido = v[31:0];
        end
        e.lido = refLido;
        e.aceite = ciclo;
        fila.push_back(e);
        ReqValido = 1'b1;
        ReqEscrita = esc;
        ReqTamanho = tam;
        ReqSinal = sin;
        EndByte = a;
        DadoEscrita = d;
        @(posedge CLK);
        #1 ReqValido = 1'b0;
    endtask

    initial begin
        int n;
        int diffs;
        logic [31:0] a;
        logic [1:0] tam;
        for (int i = 0; i < 256; i++) refMem[i] = $urandom;
        refMem[5] = 32'h8899AABB;
        repeat (2) @(negedge CLK);
        verifica("rst_pronto", Pronto, 1);
        verifica("rst_concluido", Concluido, 0);
        verifica("rst_erro", Erro, 0);
        verifica("rst_dado_lido", DadoLido, 32'h0);
        verifica("rst_we", CTRLEscritaMem, 0);
        verifica("rst_end_leitura", EndLeitura, 0);
        verifica("rst_end_escrita", EndEscrita, 0);
        preloadEn = 1'b0;
        RST = 1'b0;

        requisita(1'b0, 2'd0, 1'b1, 32'h15, 32'h0);
        drena();
        verifica("ldrb_signed", DadoLido, 32'hFFFFFFAA);
        requisita(1'b0, 2'd1, 1'b0, 32'h16, 32'h0);
        drena();
        verifica("ldrh_unsigned", DadoLido, 32'h00008899);
        requisita(1'b0, 2'd1, 1'b1, 32'h16, 32'h0);
        drena();
        verifica("ldrh_signed", DadoLido, 32'hFFFF8899);
        requisita(1'b1, 2'd0, 1'b0, 32'h17, 32'h11);
        drena();
        verifica("strb_merge", mem[5], 32'h1199AABB);
        verifica("dado_lido_mantido", DadoLido, 32'hFFFF8899);
        requisita(1'b1, 2'd2, 1'b0, 32'h3FC, 32'hDEADBEEF);
        drena();
        verifica("str_word255", mem[255], 32'hDEADBEEF);
        requisita(1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678);
        drena();
        verifica("str_wrap_word0", mem[0], 32'h12345678);
        requisita(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
        requisita(1'b0, 2'd2, 1'b0, 32'h02, 32'h0);
        requisita(1'b1, 2'd1, 1'b0, 32'h03, 32'hCAFE);
        requisita(1'b0, 2'd3, 1'b0, 32'h00, 32'h0);
        requisita(1'b1, 2'd3, 1'b0, 32'h04, 32'h1);
        drena();
        verifica("erro_dado_lido_zero", DadoLido, 32'h0);

        // Reset while the merged halfword is being written
        aguardaPronto();
        ReqValido = 1'b1;
        ReqEscrita = 1'b1;
        ReqTamanho = 2'd1;
        ReqSinal = 1'b0;
        EndByte = 32'h22;
        DadoEscrita = 32'h5555;
        @(posedge CLK);
        #1 ReqValido = 1'b0;
        n = 0;
        while (!CTRLEscritaMem && n < 5) begin
            @(posedge CLK);
            #1 n++;
        end
        verifica("we_em_mescla", CTRLEscritaMem, 1);
        RST = 1'b1;
        #1;
        verifica("rst_meio_we", CTRLEscritaMem, 0);
        verifica("rst_meio_pronto", Pronto, 1);
        verifica("rst_meio_concluido", Concluido, 0);
        @(negedge CLK);
        RST = 1'b0;
        refLido = 32'h0;
        repeat (3) @(negedge CLK);
        verifica("rst_meio_memoria", mem[8], refMem[8]);

        for (int k = 0; k < 300; k++) begin
            a = $urandom;
            tam = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a[9:2] = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (tam == 2'd1) a[0] = 1'b0;
                if (tam == 2'd2) a[1:0] = 2'b00;
            end
            requisita(1'($urandom_range(0, 1)), tam, 1'($urandom_range(0, 1)), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        drena();
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== refMem[i]) diffs++;
        verifica("memoria_final", diffs, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
